// File: rtl/float24_to_pcm.sv
// float24 -> signed PCM converter: 2-stage decode/saturate pipeline
// feeding a first-word-fall-through output FIFO with clip statistics.
module float24_to_pcm #(
    parameter int FRAC_BITS = 15,
    parameter int PCM_W     = 16,
    parameter int DEPTH     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      in_float,
    input  logic             in_underflow,
    input  logic             in_overflow,
    output logic             pcm_valid,
    input  logic             pcm_ready,
    output logic [PCM_W-1:0] pcm_data,
    output logic             clip_sticky,
    output logic [7:0]       clip_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [31:0] POS_MAX =
        32'((64'd1 << (PCM_W - 1)) - 64'd1);
    localparam logic [31:0] NEG_MAG =
        32'(64'd1 << (PCM_W - 1));

    localparam logic [PCM_W-1:0] PCM_MAX =
        {1'b0, {(PCM_W-1){1'b1}}};
    localparam logic [PCM_W-1:0] PCM_MIN =
        {1'b1, {(PCM_W-1){1'b0}}};

    localparam logic signed [9:0] SH_OFS =
        10'(FRAC_BITS - 63);

    // input decode
    logic              acc_w;
    logic              sign_w;
    logic [6:0]        exp_w;
    logic [16:0]       mag_w;
    logic signed [9:0] sh_w;
    logic [4:0]        rsh_w;
    logic [3:0]        lsh_w;
    logic [31:0]       dec_mag_d;

    // stage 1
    logic        s1_v_q;
    logic        s1_sign_q;
    logic        s1_force_q;
    logic [31:0] s1_mag_q;

    // stage 2
    logic [PCM_W-1:0] s2_data_d;
    logic             s2_clip_d;
    logic             s2_v_q;
    logic [PCM_W-1:0] s2_data_q;

    // clip statistics
    logic [7:0] clip_cnt_q;
    logic       clip_sticky_q;

    // fifo
    logic [PCM_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic [PCM_W-1:0] hold_q;
    logic             push_w;
    logic             pop_w;
    logic [CW:0]      fill_w;

    // Items already in the pipeline reserve a FIFO slot, so the
    // pipeline never has to stall and nothing is ever dropped.
    assign fill_w = {1'b0, count_q}
                  + (CW+1)'(s1_v_q)
                  + (CW+1)'(s2_v_q);

    assign in_ready = ~rst & (fill_w < (CW+1)'(DEPTH));
    assign acc_w    = in_valid & in_ready;

    assign push_w    = s2_v_q;
    assign pcm_valid = (count_q != '0);
    assign pop_w     = pcm_valid & pcm_ready;

    assign pcm_data    = pcm_valid ? mem_q[rptr_q] : hold_q;
    assign clip_sticky = clip_sticky_q;
    assign clip_count  = clip_cnt_q;

    // decode exponent/mantissa into an unsigned fixed-point magnitude
    always_comb begin
        sign_w    = in_float[23];
        exp_w     = in_float[22:16];
        mag_w     = {1'b1, in_float[15:0]};
        sh_w      = $signed({3'b000, exp_w}) + SH_OFS;
        rsh_w     = 5'(10'sd16 - sh_w);
        lsh_w     = 4'(sh_w - 10'sd16);
        dec_mag_d = '0;
        if (in_underflow || exp_w == 7'd0) begin
            dec_mag_d = '0;
        end else if (sh_w < 0) begin
            dec_mag_d = '0;
        end else if (sh_w <= 10'sd16) begin
            dec_mag_d = {15'b0, mag_w} >> rsh_w;
        end else if (sh_w <= 10'sd31) begin
            dec_mag_d = {15'b0, mag_w} << lsh_w;
        end else begin
            // would not fit 32 bits; far past full scale anyway
            dec_mag_d = '1;
        end
    end

    // stage 1 register: decoded magnitude, sign and forced overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q     <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_force_q <= 1'b0;
            s1_mag_q   <= '0;
        end else begin
            s1_v_q <= acc_w;
            if (acc_w) begin
                s1_sign_q  <= sign_w;
                s1_force_q <= in_overflow;
                s1_mag_q   <= dec_mag_d;
            end
        end
    end

    // apply sign and saturate; -1.0 is representable, so no clip
    always_comb begin
        s2_data_d = '0;
        s2_clip_d = 1'b0;
        if (s1_force_q) begin
            s2_clip_d = 1'b1;
            s2_data_d = s1_sign_q ? PCM_MIN : PCM_MAX;
        end else if (s1_sign_q) begin
            if (s1_mag_q > NEG_MAG) begin
                s2_clip_d = 1'b1;
                s2_data_d = PCM_MIN;
            end else begin
                s2_data_d = -s1_mag_q[PCM_W-1:0];
            end
        end else begin
            if (s1_mag_q > POS_MAX) begin
                s2_clip_d = 1'b1;
                s2_data_d = PCM_MAX;
            end else begin
                s2_data_d = s1_mag_q[PCM_W-1:0];
            end
        end
    end

    // stage 2 register: final sample waiting for its FIFO write
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_data_q <= s2_data_d;
            end
        end
    end

    // clip sticky flag and saturating clip counter
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_q    <= '0;
            clip_sticky_q <= 1'b0;
        end else if (s1_v_q && s2_clip_d) begin
            clip_sticky_q <= 1'b1;
            if (clip_cnt_q != 8'hFF) begin
                clip_cnt_q <= clip_cnt_q + 8'd1;
            end
        end
    end

    // occupancy bookkeeping
    always_comb begin
        count_d = count_q + CW'(push_w) - CW'(pop_w);
    end

    // fifo pointers, occupancy and last-popped hold value
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_w) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_w) begin
                rptr_q <= rptr_q + AW'(1);
                hold_q <= mem_q[rptr_q];
            end
        end
    end

    // fifo storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wptr_q] <= s2_data_q;
        end
    end

endmodule

// File: tb/tb_float24_to_pcm.sv
// Randomized self-checking bench for float24_to_pcm with an
// arithmetic reference model and queue-based latency/order tracking.
module tb_float24_to_pcm;

    localparam int DEPTH = 4;
    localparam int FRAC  = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] in_float = '0;
    logic        in_underflow = 1'b0;
    logic        in_overflow = 1'b0;
    logic        pcm_valid;
    logic        pcm_ready = 1'b0;
    logic [15:0] pcm_data;
    logic        clip_sticky;
    logic [7:0]  clip_count;

    float24_to_pcm #(
        .FRAC_BITS(FRAC),
        .PCM_W(16),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_float(in_float),
        .in_underflow(in_underflow),
        .in_overflow(in_overflow),
        .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready),
        .pcm_data(pcm_data),
        .clip_sticky(clip_sticky),
        .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int due;
    } fl_t;

    fl_t infl[$];
    int  fifo_m[$];
    int  clip_m;
    bit  sticky_m;
    int  cyc;
    bit  armed;
    bit  last_acc;
    int  total;
    int  bad;

    task automatic check(string tag,
                         logic signed [31:0] obs,
                         logic signed [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_pcm(logic [23:0] f, logic uf,
                                   logic of, output bit clip);
        real p;
        real v;
        int  n;
        clip = 1'b0;
        if (of) begin
            clip = 1'b1;
            return f[23] ? -32768 : 32767;
        end
        if (uf || f[22:16] == 7'd0) return 0;
        n = int'(f[22:16]) - 63 + FRAC;
        p = 1.0;
        if (n >= 0) repeat (n) p = p * 2.0;
        else repeat (-n) p = p / 2.0;
        v = $floor((1.0 + real'(f[15:0]) / 65536.0) * p);
        if (f[23]) begin
            if (v > 32768.0) begin
                clip = 1'b1;
                return -32768;
            end
            return -int'(v);
        end
        if (v > 32767.0) begin
            clip = 1'b1;
            return 32767;
        end
        return int'(v);
    endfunction

    function automatic logic [23:0] rnd_float();
        logic [6:0] e;
        if ($urandom_range(0, 7) == 0) e = 7'($urandom_range(0, 127));
        else e = 7'($urandom_range(40, 80));
        return {1'($urandom_range(0, 1)), e, 16'($urandom)};
    endfunction

    task automatic rnd_input();
        in_float     = rnd_float();
        in_underflow = ($urandom_range(0, 15) == 0);
        in_overflow  = ($urandom_range(0, 15) == 0);
    endtask

    // one clock: check outputs mid-cycle, then advance the model
    task automatic tick();
        bit acc;
        bit pop;
        bit c;
        bit rdy;
        int v;
        @(negedge clk);
        rdy = !rst && (fifo_m.size() + infl.size() < DEPTH);
        if (armed) check("ready", in_ready, rdy);
        if (armed && !rst) begin
            check("valid", pcm_valid, fifo_m.size() != 0);
            if (fifo_m.size() != 0)
                check("data", $signed(pcm_data), fifo_m[0]);
            if (infl.size() == 0) begin
                check("clip_count", clip_count, clip_m);
                check("clip_sticky", clip_sticky, sticky_m);
            end
        end
        acc = in_valid && rdy;
        pop = pcm_ready && fifo_m.size() != 0;
        v = 0;
        c = 1'b0;
        if (acc) v = ref_pcm(in_float, in_underflow, in_overflow, c);
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (rst) begin
            infl.delete();
            fifo_m.delete();
            clip_m   = 0;
            sticky_m = 1'b0;
            armed    = 1'b1;
            last_acc = 1'b0;
            return;
        end
        if (pop) void'(fifo_m.pop_front());
        while (infl.size() != 0 && infl[0].due <= cyc) begin
            fifo_m.push_back(infl[0].val);
            void'(infl.pop_front());
        end
        if (acc) begin
            infl.push_back('{v, cyc + 2});
            if (c) begin
                sticky_m = 1'b1;
                if (clip_m < 255) clip_m++;
            end
        end
    endtask

    // single sample with an expected value two edges after accept
    task automatic send_dir(logic [23:0] f, bit uf, bit of,
                            int exp_v, int exp_clip);
        bit got;
        in_float     = f;
        in_underflow = uf;
        in_overflow  = of;
        in_valid     = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = last_acc;
        end
        in_valid = 1'b0;
        if (!got) begin
            check("dir_accept_timeout", 0, 1);
            return;
        end
        tick();
        tick();
        check("dir_valid", pcm_valid, 1);
        check("dir_data", $signed(pcm_data), exp_v);
        check("dir_clip", clip_count, exp_clip);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got hang want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        cyc   = 0;
        armed = 1'b0;

        tick();
        do_reset();
        check("rst_valid", pcm_valid, 0);
        check("rst_data", $signed(pcm_data), 0);
        check("rst_clip", clip_count, 0);
        check("rst_sticky", clip_sticky, 0);

        pcm_ready = 1'b1;
        send_dir(24'h3D8000, 0, 0, 12288, 0);
        send_dir(24'hBE0000, 0, 0, -16384, 0);
        send_dir(24'hBF0000, 0, 0, -32768, 0);
        send_dir(24'h3F0000, 0, 0, 32767, 1);
        check("sticky_set", clip_sticky, 1);
        send_dir(24'h46A040, 0, 0, 32767, 2);
        send_dir(24'hBD1234, 0, 1, -32768, 3);
        send_dir(24'h000000, 0, 0, 0, 3);
        send_dir(24'h2FFFFF, 0, 0, 0, 3);
        send_dir(24'h3D8000, 1, 0, 0, 3);

        // backpressure
        pcm_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            rnd_input();
            tick();
            if (last_acc) n++;
        end
        check("bp_accepted", n, DEPTH);
        check("bp_ready_low", in_ready, 0);
        in_valid  = 1'b0;
        pcm_ready = 1'b1;
        n = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pcm_valid) n++;
            tick();
        end
        check("bp_drain_count", n, DEPTH);
        check("bp_recover", in_ready, 1);

        // streaming at full rate
        n = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            rnd_input();
            tick();
            if (last_acc) n++;
        end
        check("stream_accepted", n, 20);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            pcm_ready = ($urandom_range(0, 2) != 0);
            rnd_input();
            tick();
        end
        in_valid  = 1'b0;
        pcm_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        // reset with three samples buffered
        pcm_ready = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_float = 24'h3F0000;
            in_underflow = 1'b0;
            in_overflow  = 1'b0;
            tick();
            if (last_acc) n++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        check("pre_rst_accepted", n, 3);
        check("pre_rst_valid", pcm_valid, 1);
        do_reset();
        check("mid_rst_valid", pcm_valid, 0);
        check("mid_rst_clip", clip_count, 0);
        check("mid_rst_sticky", clip_sticky, 0);
        pcm_ready = 1'b1;
        send_dir(24'h3D8000, 0, 0, 12288, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
